// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: opcodes, forward-select
// encodings and the hazard stall-cause record.
package mips_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1a;

  // D-stage selects use RF/E/M/MD; E-stage selects use RF/W/M (W shares 01).
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_MD = 2'b11;

  typedef struct packed {
    logic load_use;
    logic branch_alu;
    logic branch_load;
    logic md_raw;
    logic md_waw;
    logic md_struct;
  } stall_cause_t;

endpackage

// File: rtl/md_scoreboard.sv
// Countdown scoreboard for the single outstanding multi-cycle mul/div op:
// latency counter, busy flag, destination capture and completion pulse.
module md_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned MD_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_dest,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_dest
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      md_busy <= 1'b0;
      md_dest <= '0;
    end else if (issue) begin
      count   <= 4'(MD_LAT);
      md_busy <= 1'b1;
      md_dest <= issue_dest;
    end else if (md_busy) begin
      count <= count - 4'd1;
      if (count == 4'd1) begin
        md_busy <= 1'b0;
      end
    end
  end

  // Gated by reset so an op discarded mid-flight never shows a completion.
  assign md_done = md_busy & (count == 4'd1) & ~reset;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline with a multi-cycle MD unit.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard_unit
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned MD_LAT = 4
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              branch_d,
  input  logic              md_d,
  input  logic [REG_AW-1:0] wr_addr_d,
  input  logic              wr_en_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wr_addr_e,
  input  logic [REG_AW-1:0] wr_addr_m,
  input  logic [REG_AW-1:0] wr_addr_w,
  input  logic              wr_en_e,
  input  logic              wr_en_m,
  input  logic              wr_en_w,
  input  logic              load_e,
  input  logic              load_m,
  output logic [1:0]        forward_a_d,
  output logic [1:0]        forward_b_d,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_dest
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  load_use_cycles,
  output logic [CNT_W-1:0]  md_stall_cycles
`endif
);

  stall_cause_t cause;
  logic         stall;
  logic         md_pend;
  logic         md_issue;

  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  function automatic logic [1:0] fwd_d_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst_e, input logic en_e,
    input logic [REG_AW-1:0] dst_m, input logic en_m,
    input logic [REG_AW-1:0] dst_md, input logic done
  );
    if (en_e && hit(src, dst_e))       return FWD_E;
    else if (en_m && hit(src, dst_m))  return FWD_M;
    else if (done && hit(src, dst_md)) return FWD_MD;
    else                               return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst_m, input logic en_m,
    input logic [REG_AW-1:0] dst_w, input logic en_w
  );
    if (en_m && hit(src, dst_m))      return FWD_M;
    else if (en_w && hit(src, dst_w)) return FWD_W;
    else                              return FWD_RF;
  endfunction

  always_comb begin
    cause       = '0;
    stall       = 1'b0;
    md_pend     = 1'b0;
    forward_a_d = FWD_RF;
    forward_b_d = FWD_RF;
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (!reset) begin
      md_pend = md_busy & ~md_done;

      cause.load_use    = load_e & wr_en_e &
                          ((use_rs_d & hit(rs_d, wr_addr_e)) | (use_rt_d & hit(rt_d, wr_addr_e)));
      cause.branch_alu  = branch_d & wr_en_e & ~load_e &
                          ((use_rs_d & hit(rs_d, wr_addr_e)) | (use_rt_d & hit(rt_d, wr_addr_e)));
      cause.branch_load = branch_d & load_m &
                          ((use_rs_d & hit(rs_d, wr_addr_m)) | (use_rt_d & hit(rt_d, wr_addr_m)));
      cause.md_raw      = md_pend &
                          ((use_rs_d & hit(rs_d, md_dest)) | (use_rt_d & hit(rt_d, md_dest)));
      cause.md_waw      = md_pend & wr_en_d & hit(wr_addr_d, md_dest);
      cause.md_struct   = md_pend & md_d;
      stall             = |cause;

      if (branch_d) begin
        forward_a_d = fwd_d_sel(rs_d, wr_addr_e, wr_en_e, wr_addr_m, wr_en_m, md_dest, md_done);
        forward_b_d = fwd_d_sel(rt_d, wr_addr_e, wr_en_e, wr_addr_m, wr_en_m, md_dest, md_done);
      end
      forward_a_e = fwd_e_sel(rs_e, wr_addr_m, wr_en_m, wr_addr_w, wr_en_w);
      forward_b_e = fwd_e_sel(rt_e, wr_addr_m, wr_en_m, wr_addr_w, wr_en_w);
    end
  end

  assign stall_f  = stall;
  assign stall_d  = stall;
  assign flush_e  = stall;
  assign md_issue = md_d & ~stall & ~reset;

  md_scoreboard #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT)
  ) u_md_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue      (md_issue),
    .issue_dest (wr_addr_d),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_dest    (md_dest)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic md_stall;
  assign md_stall = cause.md_raw | cause.md_waw | cause.md_struct;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= '0;
      load_use_cycles <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (cause.load_use && (load_use_cycles != '1)) begin
        load_use_cycles <= load_use_cycles + CNT_W'(1);
      end
      if (md_stall && (md_stall_cycles != '1)) begin
        md_stall_cycles <= md_stall_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: stimulus pushes expected outputs
// into a queue, a negedge monitor pops and compares.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, wr_addr_d, rs_e, rt_e, wr_addr_e, wr_addr_m, wr_addr_w;
  logic       use_rs_d, use_rt_d, branch_d, md_d, wr_en_d;
  logic       wr_en_e, wr_en_m, wr_en_w, load_e, load_m;
  logic [1:0] forward_a_d, forward_b_d, forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_e, md_busy, md_done;
  logic [4:0] md_dest;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, load_use_cycles, md_stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .REG_AW (5),
    .MD_LAT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .use_rs_d    (use_rs_d),
    .use_rt_d    (use_rt_d),
    .branch_d    (branch_d),
    .md_d        (md_d),
    .wr_addr_d   (wr_addr_d),
    .wr_en_d     (wr_en_d),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .wr_addr_e   (wr_addr_e),
    .wr_addr_m   (wr_addr_m),
    .wr_addr_w   (wr_addr_w),
    .wr_en_e     (wr_en_e),
    .wr_en_m     (wr_en_m),
    .wr_en_w     (wr_en_w),
    .load_e      (load_e),
    .load_m      (load_m),
    .forward_a_d (forward_a_d),
    .forward_b_d (forward_b_d),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_e     (flush_e),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_dest     (md_dest)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .load_use_cycles (load_use_cycles),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  // {fa_d, fb_d, fa_e, fb_e, stall_f, stall_d, flush_e, md_busy, md_done, md_dest}
  typedef struct {
    string       name;
    logic [17:0] exp;
    logic        perf0;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [17:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {forward_a_d, forward_b_d, forward_a_e, forward_b_e,
             stall_f, stall_d, flush_e, md_busy, md_done, md_dest};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got=%b required=%b", e.name, got, e.exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e.perf0) begin
        checks++;
        if ({stall_cycles, load_use_cycles, md_stall_cycles} !== 96'd0) begin
          errors++;
          $display("FAIL %s_perf: got=%0d/%0d/%0d required=0/0/0", e.name,
                   stall_cycles, load_use_cycles, md_stall_cycles);
        end
      end
`endif
    end
  end

  task automatic idle();
    {rs_d, rt_d, wr_addr_d, rs_e, rt_e, wr_addr_e, wr_addr_m, wr_addr_w} = '0;
    {use_rs_d, use_rt_d, branch_d, md_d, wr_en_d}                        = '0;
    {wr_en_e, wr_en_m, wr_en_w, load_e, load_m}                          = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string n, input logic [1:0] fad, input logic [1:0] fbd,
                     input logic [1:0] fae, input logic [1:0] fbe, input logic st,
                     input logic bz, input logic dn, input logic [4:0] ds,
                     input logic p0 = 1'b0);
    exp_t e;
    e.name  = n;
    e.exp   = {fad, fbd, fae, fbe, {3{st}}, bz, dn, ds};
    e.perf0 = p0;
    sb.push_back(e);
  endtask

  task automatic load_use_vec();
    load_e = 1; wr_en_e = 1; wr_addr_e = 5'd2; rs_d = 5'd2; use_rs_d = 1;
  endtask

  task automatic zero_vec();
    {use_rs_d, use_rt_d, branch_d, md_d, wr_en_d} = '1;
    {wr_en_e, wr_en_m, wr_en_w, load_e, load_m}   = '1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    idle();
    step(); load_use_vec();
    chk("reset_forced", 0, 0, 0, 0, 0, 0, 0, 5'd0, 1'b1);

    // Load-use and E-stage forwarding
    step(); reset = 1'b0; load_use_vec();
    chk("load_use_stall", 0, 0, 0, 0, 1, 0, 0, 5'd0);
    step(); wr_en_m = 1; wr_addr_m = 5'd2; load_m = 1; rs_e = 5'd2; rt_e = 5'd4;
    chk("e_fwd_m_after_load", 0, 0, 2'b10, 0, 0, 0, 0, 5'd0);
    step(); wr_en_m = 1; wr_addr_m = 5'd6; wr_en_w = 1; wr_addr_w = 5'd6; rs_e = 5'd6; rt_e = 5'd9;
    chk("e_m_beats_w", 0, 0, 2'b10, 0, 0, 0, 0, 5'd0);
    step(); wr_en_w = 1; wr_addr_w = 5'd9; wr_addr_m = 5'd9; rt_e = 5'd9;
    chk("e_fwd_w", 0, 0, 0, 2'b01, 0, 0, 0, 5'd0);

    // Branch hazards in D
    step(); branch_d = 1; rs_d = 5'd3; use_rs_d = 1; rt_d = 5'd8; use_rt_d = 1;
            wr_en_e = 1; wr_addr_e = 5'd3;
    chk("branch_alu_stall", 2'b01, 0, 0, 0, 1, 0, 0, 5'd0);
    step(); branch_d = 1; rs_d = 5'd3; use_rs_d = 1; rt_d = 5'd8; use_rt_d = 1;
            wr_en_m = 1; wr_addr_m = 5'd3;
    chk("branch_fwd_m", 2'b10, 0, 0, 0, 0, 0, 0, 5'd0);
    step(); branch_d = 1; rs_d = 5'd3; use_rs_d = 1; rt_d = 5'd8; use_rt_d = 1;
            wr_en_m = 1; wr_addr_m = 5'd3; load_m = 1;
    chk("branch_load_stall", 2'b10, 0, 0, 0, 1, 0, 0, 5'd0);
    step(); branch_d = 1; rs_d = 5'd1; use_rs_d = 1; rt_d = 5'd4; use_rt_d = 1;
            wr_en_e = 1; wr_addr_e = 5'd4; wr_en_m = 1; wr_addr_m = 5'd4;
    chk("branch_e_beats_m", 0, 2'b01, 0, 0, 1, 0, 0, 5'd0);
    step(); rs_d = 5'd3; use_rs_d = 1; wr_en_m = 1; wr_addr_m = 5'd3;
    chk("nonbranch_no_dfwd", 0, 0, 0, 0, 0, 0, 0, 5'd0);

    // MD op to $5 with dependent branch
    step(); md_d = 1; wr_en_d = 1; wr_addr_d = 5'd5;
    chk("md_issue", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(); branch_d = 1; rs_d = 5'd5; use_rs_d = 1;
      chk($sformatf("md_raw_stall%0d", i), 0, 0, 0, 0, 1, 1, 0, 5'd5);
    end
    step(); branch_d = 1; rs_d = 5'd5; use_rs_d = 1;
    chk("md_done_fwd", 2'b11, 0, 0, 0, 0, 1, 1, 5'd5);

    // Back-to-back MD issue on the md_done cycle
    step(); md_d = 1; wr_en_d = 1; wr_addr_d = 5'd5;
    chk("md_reissue_idle", 0, 0, 0, 0, 0, 0, 0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("md_busy%0d", i), 0, 0, 0, 0, 0, 1, 0, 5'd5);
    end
    step(); md_d = 1; wr_en_d = 1; wr_addr_d = 5'd7;
    chk("md_b2b_issue", 0, 0, 0, 0, 0, 1, 1, 5'd5);
    step();
    chk("md_b2b_reload", 0, 0, 0, 0, 0, 1, 0, 5'd7);
    step(); md_d = 1;
    chk("md_struct_stall", 0, 0, 0, 0, 1, 1, 0, 5'd7);
    step(); wr_en_d = 1; wr_addr_d = 5'd7;
    chk("md_waw_stall", 0, 0, 0, 0, 1, 1, 0, 5'd7);
    step();
    chk("md_b2b_done", 0, 0, 0, 0, 0, 1, 1, 5'd7);
    step();
    chk("md_idle", 0, 0, 0, 0, 0, 0, 0, 5'd7);

    // Register $0 with every enable high
    step(); zero_vec();
    chk("zero_all", 0, 0, 0, 0, 0, 0, 0, 5'd7);
    step(); zero_vec(); md_d = 0;
    chk("zero_md_pending", 0, 0, 0, 0, 0, 1, 0, 5'd0);

    // Reset on the 2nd cycle of the MD op
    step(); reset = 1'b1; load_use_vec(); md_d = 1; wr_addr_d = 5'd9;
    chk("reset_mid_md", 0, 0, 0, 0, 0, 1, 0, 5'd0);
    step(); reset = 1'b0;
    chk("after_reset", 0, 0, 0, 0, 0, 0, 0, 5'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("no_done_after_reset%0d", i), 0, 0, 0, 0, 0, 0, 0, 5'd0);
    end

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
